// File: rtl/lsu_load_store_unit.sv
// lsu_load_store_unit: memory-stage load/store unit with req/ready handshake, lane alignment and load extension
module lsu_load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic [31:0] load_data,
   output logic        lsu_fault,
   output logic [1:0]  fault_cause,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;
   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  f3;
   logic [1:0]  off;
   logic        op, illegal, misaligned;
   logic [31:0] wdata, ext;
   logic [3:0]  be;
   logic [7:0]  b;
   logic [15:0] h;
   // decode the presented op and build store lanes and extended load data
   always_comb begin
      op = ex_valid && (ex_is_load || ex_is_store);
      illegal = (ex_is_load && ex_is_store) ||
                (ex_is_load && (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11)) ||
                (ex_is_store && (ex_funct3 == 3'b011 || ex_funct3[2]));
      misaligned = (ex_funct3[1:0] == 2'b01 && ex_addr[0]) || (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);
      wdata = ex_funct3[1:0] == 2'b00 ? {4{ex_store_data[7:0]}} :
              ex_funct3[1:0] == 2'b01 ? {2{ex_store_data[15:0]}} : ex_store_data;
      be = !ex_is_store ? 4'b1111 :
           ex_funct3[1:0] == 2'b00 ? 4'b0001 << ex_addr[1:0] :
           ex_funct3[1:0] == 2'b01 ? (ex_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      b = mem_rdata[{off, 3'b000} +: 8];
      h = mem_rdata[{off[1], 4'b0000} +: 16];
      ext = f3[1:0] == 2'b00 ? {{24{b[7] & ~f3[2]}}, b} :
            f3[1:0] == 2'b01 ? {{16{h[15] & ~f3[2]}}, h} : mem_rdata;
      lsu_busy = (state == IDLE && op) || state == REQ;
   end
   // access sequencer: accept or fault in IDLE, wait for ready or timeout in REQ, one-cycle result pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         f3          <= '0;
         off         <= '0;
         lsu_done    <= 1'b0;
         lsu_fault   <= 1'b0;
         fault_cause <= '0;
         load_data   <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
      end else begin
         lsu_done  <= 1'b0;
         lsu_fault <= 1'b0;
         case (state)
            IDLE: if (op) begin
               if (illegal || misaligned) begin
                  fault_cause <= illegal ? 2'b10 : 2'b01;
                  lsu_fault   <= 1'b1;
                  state       <= FAULT;
               end else begin
                  mem_req   <= 1'b1;
                  mem_we    <= ex_is_store;
                  mem_addr  <= {ex_addr[31:2], 2'b00};
                  mem_wdata <= wdata;
                  mem_be    <= be;
                  f3        <= ex_funct3;
                  off       <= ex_addr[1:0];
                  cnt       <= '0;
                  state     <= REQ;
               end
            end
            REQ: if (mem_ready) begin
               mem_req  <= 1'b0;
               lsu_done <= 1'b1;
               if (!mem_we) load_data <= ext;
               state    <= DONE;
            end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
               mem_req     <= 1'b0;
               fault_cause <= 2'b11;
               lsu_fault   <= 1'b1;
               cnt         <= '0;
               state       <= FAULT;
            end else begin
               cnt <= cnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_load_store_unit.sv
// tb_lsu_load_store_unit: randomized and directed checks of the load/store unit against a behavioural model
module tb_lsu_load_store_unit;
   logic        clk = 0, rst = 0, use_t = 0;
   logic        ex_valid = 0, ex_is_load = 0, ex_is_store = 0, mem_ready = 0;
   logic [2:0]  ex_funct3 = 0;
   logic [31:0] ex_addr = 0, ex_store_data = 0, mem_rdata = 0;
   logic        busy_a, done_a, fault_a, req_a, we_a, busy_b, done_b, fault_b, req_b, we_b;
   logic [1:0]  cause_a, cause_b;
   logic [3:0]  be_a, be_b;
   logic [31:0] ld_a, addr_a, wd_a, ld_b, addr_b, wd_b;
   logic        lsu_busy, lsu_done, lsu_fault, mem_req, mem_we;
   logic [1:0]  fault_cause;
   logic [3:0]  mem_be;
   logic [31:0] load_data, mem_addr, mem_wdata, exp_ld;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   lsu_load_store_unit dut_a (
      .clk(clk), .rst(rst), .ex_valid(ex_valid & ~use_t), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .lsu_busy(busy_a), .lsu_done(done_a),
      .load_data(ld_a), .lsu_fault(fault_a), .fault_cause(cause_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
      .mem_wdata(wd_a), .mem_be(be_a), .mem_ready(mem_ready & ~use_t), .mem_rdata(mem_rdata));

   lsu_load_store_unit #(.TIMEOUT_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .ex_valid(ex_valid & use_t), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .lsu_busy(busy_b), .lsu_done(done_b),
      .load_data(ld_b), .lsu_fault(fault_b), .fault_cause(cause_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
      .mem_wdata(wd_b), .mem_be(be_b), .mem_ready(mem_ready & use_t), .mem_rdata(mem_rdata));

   assign lsu_busy = use_t ? busy_b : busy_a;
   assign lsu_done = use_t ? done_b : done_a;
   assign lsu_fault = use_t ? fault_b : fault_a;
   assign fault_cause = use_t ? cause_b : cause_a;
   assign load_data = use_t ? ld_b : ld_a;
   assign mem_req = use_t ? req_b : req_a;
   assign mem_we = use_t ? we_b : we_a;
   assign mem_addr = use_t ? addr_b : addr_a;
   assign mem_wdata = use_t ? wd_b : wd_a;
   assign mem_be = use_t ? be_b : be_a;

   function automatic logic [1:0] model_cause(bit ld, bit st, logic [2:0] f3, logic [31:0] a);
      int sz;
      if (ld && st) return 2'b10;
      if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b10;
      if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) return 2'b10;
      sz = 1 << f3[1:0];
      if (int'(a[1:0]) % sz != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] model_be(bit st, logic [2:0] f3, logic [31:0] a);
      logic [3:0] r;
      int sz, lo;
      sz = 1 << f3[1:0];
      lo = int'(a[1:0]);
      for (int i = 0; i < 4; i++) r[i] = !st || (i >= lo && i < lo + sz);
      return r;
   endfunction

   function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
      logic [31:0] r;
      int sz;
      sz = 1 << f3[1:0];
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
      logic [31:0] bv, hv;
      bv = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      hv = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      case (f3)
         3'd0: return bv >= 128 ? bv - 256 : bv;
         3'd1: return hv >= 32768 ? hv - 65536 : hv;
         3'd4: return bv;
         3'd5: return hv;
         default: return rd;
      endcase
   endfunction

   task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int wait_n, input string tag);
      logic [1:0] cause;
      int to;
      bit fin;
      cause = model_cause(ld, st, f3, a);
      to = use_t ? 4 : 255;
      @(negedge clk);
      ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3; ex_addr = a; ex_store_data = d;
      #1;
      total++; if (lsu_busy !== 1'b1) begin bad++; $display("FAIL %s accept busy: got %b want 1", tag, lsu_busy); end
      if (cause != 2'b00) begin
         @(negedge clk);
         total++; if (lsu_fault !== 1'b1 || fault_cause !== cause) begin bad++; $display("FAIL %s fault: got %b/%b want 1/%b", tag, lsu_fault, fault_cause, cause); end
         total++; if (mem_req !== 1'b0 || lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin bad++; $display("FAIL %s fault side: req %b busy %b done %b want 0", tag, mem_req, lsu_busy, lsu_done); end
      end else begin
         fin = 0;
         for (int i = 0; i < to && !fin; i++) begin
            @(negedge clk);
            total++; if (mem_req !== 1'b1 || lsu_busy !== 1'b1) begin bad++; $display("FAIL %s req cyc %0d: req %b busy %b want 1", tag, i, mem_req, lsu_busy); end
            total++; if (mem_addr !== {a[31:2], 2'b00} || mem_we !== st || mem_be !== model_be(st, f3, a)) begin
               bad++; $display("FAIL %s bus cyc %0d: addr %h we %b be %b want %h %b %b", tag, i, mem_addr, mem_we, mem_be, {a[31:2], 2'b00}, st, model_be(st, f3, a)); end
            if (st) begin
               total++; if (mem_wdata !== model_wdata(f3, d)) begin bad++; $display("FAIL %s wdata cyc %0d: got %h want %h", tag, i, mem_wdata, model_wdata(f3, d)); end
            end
            if (i == wait_n) begin mem_ready = 1; mem_rdata = rd; fin = 1; end
            else begin mem_ready = 0; mem_rdata = $urandom; end
         end
         @(negedge clk);
         mem_ready = 0;
         if (fin) begin
            if (ld) exp_ld = model_load(f3, a, rd);
            total++; if (lsu_done !== 1'b1 || lsu_fault !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL %s done: done %b fault %b req %b want 1 0 0", tag, lsu_done, lsu_fault, mem_req); end
         end else begin
            total++; if (lsu_fault !== 1'b1 || fault_cause !== 2'b11 || lsu_done !== 1'b0 || mem_req !== 1'b0) begin
               bad++; $display("FAIL %s timeout: fault %b cause %b done %b req %b want 1 11 0 0", tag, lsu_fault, fault_cause, lsu_done, mem_req); end
         end
         total++; if (load_data !== exp_ld) begin bad++; $display("FAIL %s load_data: got %h want %h", tag, load_data, exp_ld); end
      end
      ex_valid = 0;
      @(negedge clk);
      total++; if (lsu_done !== 1'b0 || lsu_fault !== 1'b0 || lsu_busy !== 1'b0) begin bad++; $display("FAIL %s after: done %b fault %b busy %b want 0", tag, lsu_done, lsu_fault, lsu_busy); end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(negedge clk);
      total++; if ({lsu_busy, lsu_done, lsu_fault, fault_cause, mem_req, mem_we, mem_be} !== 10'b0 || load_data !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
         bad++; $display("FAIL reset: ctl %b ld %h addr %h wd %h want 0", {lsu_busy, lsu_done, lsu_fault, fault_cause, mem_req, mem_we, mem_be}, load_data, mem_addr, mem_wdata); end
      rst = 0;
      exp_ld = 0;
   endtask

   task automatic test_load;
      run_op(1, 0, 3'd0, 32'h1003, 0, 32'h80FF_1234, 0, "lb");
      total++; if (load_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb value: got %h want ffffff80", load_data); end
      run_op(1, 0, 3'd4, 32'h1003, 0, 32'h80FF_1234, 0, "lbu");
      total++; if (load_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu value: got %h want 00000080", load_data); end
   endtask

   task automatic test_store;
      run_op(0, 1, 3'd1, 32'h2002, 32'hDEAD_BEEF, 0, 4, "sh");
      total++; if (load_data !== 32'h0000_0080) begin bad++; $display("FAIL sh keeps load_data: got %h want 00000080", load_data); end
   endtask

   task automatic test_fault;
      run_op(1, 0, 3'd2, 32'h3001, 0, 0, 0, "lw_misaligned");
      run_op(0, 1, 3'd4, 32'h3000, 32'h1, 0, 0, "st_f3_100");
      run_op(1, 1, 3'd0, 32'h3000, 32'h1, 0, 0, "ld_and_st");
      total++; if (fault_cause !== 2'b10 || load_data !== exp_ld) begin bad++; $display("FAIL cause hold: cause %b ld %h want 10 %h", fault_cause, load_data, exp_ld); end
   endtask

   task automatic test_timeout;
      logic [31:0] saved;
      saved = exp_ld;
      use_t = 1;
      exp_ld = 0;
      run_op(1, 0, 3'd2, 32'h5000, 0, 0, 1000, "timeout");
      run_op(1, 0, 3'd2, 32'h5004, 0, 32'h1357_9BDF, 1, "lw_after_timeout");
      total++; if (load_data !== 32'h1357_9BDF) begin bad++; $display("FAIL lw after timeout: got %h want 13579bdf", load_data); end
      use_t = 0;
      exp_ld = saved;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      ex_valid = 1; ex_is_load = 0; ex_is_store = 1; ex_funct3 = 3'd2; ex_addr = 32'h4000; ex_store_data = $urandom;
      @(negedge clk);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid req: got %b want 1", mem_req); end
      @(negedge clk);
      rst = 1; ex_valid = 0;
      @(negedge clk);
      rst = 0;
      total++; if ({lsu_busy, lsu_done, lsu_fault, fault_cause, mem_req, mem_we, mem_be} !== 10'b0 || load_data !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
         bad++; $display("FAIL rst_mid outputs: ctl %b ld %h addr %h want 0", {lsu_busy, lsu_done, lsu_fault, fault_cause, mem_req, mem_we, mem_be}, load_data, mem_addr); end
      @(negedge clk);
      total++; if (lsu_done !== 1'b0 || lsu_fault !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rst_mid pulses: done %b fault %b req %b want 0", lsu_done, lsu_fault, mem_req); end
      exp_ld = 0;
      run_op(1, 0, 3'd1, 32'h0002, 0, 32'h8001_0000, 0, "lh_after_rst");
      total++; if (load_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh after rst: got %h want ffff8001", load_data); end
   endtask

   task automatic test_back_to_back;
      int k, accepts, dones, faults;
      bit prev_req, bsy;
      k = 0; accepts = 0; dones = 0; faults = 0; prev_req = 0;
      mem_rdata = 32'h0000_9ABC;
      @(posedge clk); #1;
      ex_valid = 1; ex_is_load = 0; ex_is_store = 1; ex_funct3 = 3'd2; ex_addr = 32'h10; ex_store_data = 32'hCAFE_F00D;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (mem_req && !prev_req) begin
            accepts++;
            total++; if (mem_we !== (k == 0)) begin bad++; $display("FAIL b2b we op %0d: got %b want %b", k, mem_we, k == 0); end
         end
         prev_req = mem_req;
         dones += int'(lsu_done);
         faults += int'(lsu_fault);
         mem_ready = mem_req;
         bsy = lsu_busy;
         @(posedge clk); #1;
         if (!bsy && ex_valid) begin
            k++;
            if (k == 1) begin ex_is_load = 1; ex_is_store = 0; ex_funct3 = 3'd5; ex_addr = 32'h0; end
            else ex_valid = 0;
         end
      end
      mem_ready = 0;
      exp_ld = 32'h0000_9ABC;
      total++; if (accepts != 2 || dones != 2 || faults != 0) begin bad++; $display("FAIL b2b counts: acc %0d done %0d fault %0d want 2 2 0", accepts, dones, faults); end
      total++; if (load_data !== 32'h0000_9ABC) begin bad++; $display("FAIL b2b lhu: got %h want 00009abc", load_data); end
   endtask

   task automatic test_random;
      int r;
      bit ld, st;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         ld = r < 5 || r == 9;
         st = r >= 5;
         run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom_range(0, 3), "rand");
      end
   endtask

   initial begin
      test_reset;
      test_load;
      test_store;
      test_fault;
      test_timeout;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
